// File: rtl/cdc_hs_src_ctrl.sv
// Source-side controller for a four-phase req/ack clock-domain-crossing handshake.
// Optional watchdog/error state is enabled by defining CDC_HS_TIMEOUT_EN.
module cdc_hs_src_ctrl #(
    parameter int DATA_W      = 32,
    parameter int SYNC_DEPTH  = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic [DATA_W-1:0] S_DATA,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              REQ_OUT,
    input  logic              ACK_IN,
    output logic              DONE,
    output logic              BUSY,
    input  logic              ERR_CLR,
    output logic              TIMEOUT_ERR
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;
`ifdef CDC_HS_TIMEOUT_EN
    localparam logic [1:0] ST_ERR  = 2'd3;
`endif

    logic              ack_s;
    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              capture_s;
    logic              timeout_hit_s;
    logic [DATA_W-1:0] data_r;
    logic              req_r;
    logic              done_r;

    generate
        if (SYNC_DEPTH == 0) begin : g_no_sync
            assign ack_s = ACK_IN;
        end else begin : g_sync
            logic [SYNC_DEPTH-1:0] sync_r;

            // Resynchronize the destination acknowledge into CLK
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    sync_r <= '0;
                end else begin
                    sync_r[0] <= ACK_IN;
                    for (int i = 1; i < SYNC_DEPTH; i++) begin
                        sync_r[i] <= sync_r[i-1];
                    end
                end
            end

            assign ack_s = sync_r[SYNC_DEPTH-1];
        end
    endgenerate

`ifdef CDC_HS_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_r;

    // Handshake watchdog: cleared on capture, saturating while a handshake runs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r <= '0;
        end else if (capture_s) begin
            cnt_r <= '0;
        end else if (((state_r == ST_REQ) || (state_r == ST_REL)) && (cnt_r < CNT_SAT)) begin
            cnt_r <= cnt_r + 1'b1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // >= rather than == so a handshake that reached REL on the last allowed
    // edge (ack won the race) still times out instead of hanging at saturation.
    assign timeout_hit_s = (cnt_r >= CNT_LAST);
`else
    logic        unused_err_clr_s;
    logic [31:0] unused_timeout_cyc_s;

    assign unused_err_clr_s     = ERR_CLR;
    assign unused_timeout_cyc_s = 32'(TIMEOUT_CYC);
    assign timeout_hit_s        = 1'b0;
`endif

    // Next-state decode; ack_s is only looked at while a handshake is running
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (S_VALID) begin
                    state_nxt_s = ST_REQ;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    state_nxt_s = ST_REL;
`ifdef CDC_HS_TIMEOUT_EN
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_ERR;
`endif
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_REL: begin
                if (!ack_s) begin
                    state_nxt_s = ST_IDLE;
`ifdef CDC_HS_TIMEOUT_EN
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_ERR;
`endif
                end else begin
                    state_nxt_s = ST_REL;
                end
            end
`ifdef CDC_HS_TIMEOUT_EN
            ST_ERR: begin
                if (ERR_CLR && !ack_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, captured word, and registered REQ/DONE outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            data_r  <= '0;
            req_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                data_r <= S_DATA;
            end else begin
                data_r <= data_r;
            end
            req_r  <= (state_nxt_s == ST_REQ);
            done_r <= (state_r == ST_REL) && (state_nxt_s == ST_IDLE);
        end
    end

    assign S_READY  = (state_r == ST_IDLE);
    assign BUSY     = (state_r == ST_REQ) || (state_r == ST_REL);
    assign DATA_OUT = data_r;
    assign REQ_OUT  = req_r;
    assign DONE     = done_r;
`ifdef CDC_HS_TIMEOUT_EN
    assign TIMEOUT_ERR = (state_r == ST_ERR);
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_src_ctrl.sv
// Self-checking bench for cdc_hs_src_ctrl (SYNC_DEPTH=2, TIMEOUT_CYC=16).
// Follows the CDC_HS_TIMEOUT_EN build of the design for the timeout scenario.
module tb_cdc_hs_src_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        S_VALID = 1'b0;
    logic        S_READY;
    logic [31:0] S_DATA = 32'h0;
    logic [31:0] DATA_OUT;
    logic        REQ_OUT;
    logic        ACK_IN = 1'b0;
    logic        DONE;
    logic        BUSY;
    logic        ERR_CLR = 1'b0;
    logic        TIMEOUT_ERR;

    int n_checks = 0;
    int n_errs   = 0;

    cdc_hs_src_ctrl #(
        .DATA_W(32),
        .SYNC_DEPTH(2),
        .TIMEOUT_CYC(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .S_VALID(S_VALID),
        .S_READY(S_READY),
        .S_DATA(S_DATA),
        .DATA_OUT(DATA_OUT),
        .REQ_OUT(REQ_OUT),
        .ACK_IN(ACK_IN),
        .DONE(DONE),
        .BUSY(BUSY),
        .ERR_CLR(ERR_CLR),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        s_valid;
        logic [31:0] s_data;
        logic        ack;
        logic        e_ready;
        logic        e_req;
        logic        e_done;
        logic        e_busy;
        logic [31:0] e_data;
    } vec_t;

    vec_t vt[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic a,
                                input logic rdy, input logic rq, input logic dn, input logic bz);
        vec_t r;
        r.s_valid = v;
        r.s_data  = d;
        r.ack     = a;
        r.e_ready = rdy;
        r.e_req   = rq;
        r.e_done  = dn;
        r.e_busy  = bz;
        r.e_data  = 32'hA5A50001;
        return r;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_data"},  DATA_OUT, 32'h0);
        check({tag, "_req"},   {31'h0, REQ_OUT}, 32'h0);
        check({tag, "_done"},  {31'h0, DONE}, 32'h0);
        check({tag, "_busy"},  {31'h0, BUSY}, 32'h0);
        check({tag, "_terr"},  {31'h0, TIMEOUT_ERR}, 32'h0);
        check({tag, "_ready"}, {31'h0, S_READY}, 32'h1);
    endtask

    initial begin
        logic [31:0] words[3];
        int          k;
        int          dones;
        int          last_cap;
        int          t;
        int          hi;
        logic        prev_busy;
        logic [31:0] prev_data;

        // single word with slow destination; S_DATA churns while busy
        vt[0]  = mk(1'b1, 32'hA5A50001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vt[1]  = mk(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vt[2]  = mk(1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vt[3]  = mk(1'b1, 32'h33333333, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vt[4]  = mk(1'b1, 32'h44444444, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        vt[5]  = mk(1'b1, 32'h55555555, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        vt[6]  = mk(1'b1, 32'h66666666, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        vt[7]  = mk(1'b1, 32'h77777777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vt[8]  = mk(1'b1, 32'h88888888, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vt[9]  = mk(1'b1, 32'h99999999, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        vt[10] = mk(1'b0, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // spurious ack while idle must be ignored
        vt[11] = mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[12] = mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[13] = mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[14] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[15] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[16] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset
        RST = 1'b1;
        tick(); tick(); tick();
        check_reset_vals("reset");
        RST = 1'b0;

        // table-driven single-word transfer
        for (int i = 0; i < 17; i++) begin
            S_VALID = vt[i].s_valid;
            S_DATA  = vt[i].s_data;
            ACK_IN  = vt[i].ack;
            tick();
            check($sformatf("vec%0d_ready", i), {31'h0, S_READY}, {31'h0, vt[i].e_ready});
            check($sformatf("vec%0d_req", i),   {31'h0, REQ_OUT}, {31'h0, vt[i].e_req});
            check($sformatf("vec%0d_done", i),  {31'h0, DONE},    {31'h0, vt[i].e_done});
            check($sformatf("vec%0d_busy", i),  {31'h0, BUSY},    {31'h0, vt[i].e_busy});
            check($sformatf("vec%0d_data", i),  DATA_OUT, vt[i].e_data);
        end

        // back-to-back words with a destination that echoes REQ_OUT
        words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h3;
        k = 0; dones = 0; last_cap = 0;
        S_VALID = 1'b1; S_DATA = words[0];
        prev_busy = BUSY; prev_data = DATA_OUT;
        for (int c = 0; c < 60 && dones < 3; c++) begin
            tick();
            ACK_IN = REQ_OUT;
            if (BUSY && !prev_busy) begin
                check($sformatf("b2b_data%0d", k), DATA_OUT, words[k]);
                if (k > 0) check($sformatf("b2b_interval%0d", k), 32'(c - last_cap), 32'd7);
                last_cap = c;
                k++;
                if (k < 3) S_DATA = words[k];
                else S_VALID = 1'b0;
            end else if (DATA_OUT !== prev_data) begin
                check("b2b_hold", DATA_OUT, prev_data);
            end
            if (DONE) dones++;
            prev_busy = BUSY;
            prev_data = DATA_OUT;
        end
        check("b2b_captures", 32'(k), 32'd3);
        check("b2b_dones", 32'(dones), 32'd3);
        ACK_IN = 1'b0;
        tick(); tick(); tick();

`ifdef CDC_HS_TIMEOUT_EN
        // watchdog fires 16 edges after capture with no ack
        S_VALID = 1'b1; S_DATA = 32'hC0DE; tick(); S_VALID = 1'b0;
        check("to_req_up", {31'h0, REQ_OUT}, 32'h1);
        t = 0;
        while (!TIMEOUT_ERR && t < 40) begin
            tick();
            t++;
        end
        check("to_edges", 32'(t), 32'd16);
        check("to_req", {31'h0, REQ_OUT}, 32'h0);
        check("to_ready", {31'h0, S_READY}, 32'h0);
        check("to_busy", {31'h0, BUSY}, 32'h0);
        check("to_data", DATA_OUT, 32'hC0DE);
        tick();
        check("to_sticky", {31'h0, TIMEOUT_ERR}, 32'h1);
        ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
        check("clr_terr", {31'h0, TIMEOUT_ERR}, 32'h0);
        check("clr_ready", {31'h0, S_READY}, 32'h1);
        check("clr_done", {31'h0, DONE}, 32'h0);
        tick();
        check("clr_done_after", {31'h0, DONE}, 32'h0);
`else
        // without the watchdog the block waits indefinitely for ack
        S_VALID = 1'b1; S_DATA = 32'hC0DE; tick(); S_VALID = 1'b0;
        hi = 0;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (REQ_OUT) hi++;
        end
        check("stuck_req_cycles", 32'(hi), 32'd120);
        check("stuck_terr", {31'h0, TIMEOUT_ERR}, 32'h0);
        ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
        check("stuck_errclr_ignored", {31'h0, REQ_OUT}, 32'h1);
`endif

        // asynchronous reset while in REL
        if (S_READY) begin
            S_VALID = 1'b1; S_DATA = 32'hDEAD; tick(); S_VALID = 1'b0;
        end
        ACK_IN = 1'b1;
        t = 0;
        while (!(BUSY && !REQ_OUT) && t < 10) begin
            tick();
            t++;
        end
        check("rst_reached_rel", {31'h0, BUSY && !REQ_OUT}, 32'h1);
        #3 RST = 1'b1;
        #1 check_reset_vals("async_rst");
        ACK_IN = 1'b0;
        tick(); tick();
        RST = 1'b0;
        check("post_rst_ready", {31'h0, S_READY}, 32'h1);

        // clean transfer after reset
        S_VALID = 1'b1; S_DATA = 32'h5A; dones = 0;
        tick(); S_VALID = 1'b0; S_DATA = 32'hFFFF;
        check("x5a_capture", DATA_OUT, 32'h5A);
        for (int c = 0; c < 30; c++) begin
            ACK_IN = REQ_OUT;
            tick();
            if (DONE) dones++;
        end
        check("x5a_dones", 32'(dones), 32'd1);
        check("x5a_data", DATA_OUT, 32'h5A);
        check("x5a_idle", {31'h0, S_READY}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/cdc_hs_src_ctrl.md
# cdc_hs_src_ctrl

Source-side controller for a four-phase req/ack clock-domain-crossing handshake. It accepts a word on a valid/ready port and holds it stable on `DATA_OUT` while it runs the `REQ_OUT`/`ACK_IN` handshake to completion. `ACK_IN` comes from the destination domain and is resynchronized internally through a multi-flop synchronizer chain. The block sits at the source edge of any multi-bit crossing and is paired with a destination-side capture block.

## Interface

**Parameters**
- `DATA_W`, 32: width of the transferred word.
- `SYNC_DEPTH`, 2: number of flops in the `ACK_IN` synchronizer chain. 0 means `ACK_IN` is used directly with no resynchronization.
- `TIMEOUT_CYC`, 1024: watchdog limit in cycles, ≥2. Used only when `CDC_HS_TIMEOUT_EN` is defined.

**Ports**
- `CLK` in, 1: the only clock.
- `RST` in, 1: asynchronous, active-high reset.
- `S_VALID` in, 1: a source word is offered.
- `S_READY` out, 1: the block can accept a word.
- `S_DATA` in, `DATA_W`: the source word.
- `DATA_OUT` out, `DATA_W`: the captured word, driven to the destination domain.
- `REQ_OUT` out, 1: handshake request, registered.
- `ACK_IN` in, 1: handshake acknowledge, asynchronous to `CLK`.
- `DONE` out, 1: one-cycle pulse when a handshake completes.
- `BUSY` out, 1: a handshake is in progress.
- `ERR_CLR` in, 1: clears the timeout error state.
- `TIMEOUT_ERR` out, 1: the block is in the timeout error state.

## Operation

**Synchronizer**
- `ACK_IN` passes through a `SYNC_DEPTH`-stage flop chain. The chain resets to 0.
- The chain output is `ack_s`.

**State machine**
- States: IDLE, REQ, REL, and ERR (ERR exists only with the macro).
- Transitions:
  - IDLE → REQ when `S_VALID & S_READY` at a clock edge. On that edge: `DATA_OUT <= S_DATA` and `REQ_OUT <= 1`.
  - REQ → REL when `ack_s == 1`. On that edge `REQ_OUT <= 0`.
  - REL → IDLE when `ack_s == 0`. On that edge `DONE <= 1`. `DONE` is cleared on every other edge.

**Output rules**
- `S_READY = (state == IDLE)`, combinational.
- `BUSY = (state == REQ) | (state == REL)`.
- `DATA_OUT` changes only on the IDLE → REQ edge. It holds through REQ, REL, ERR, and the following IDLE cycles.
- `S_DATA` is ignored whenever `S_READY == 0`.
- The block never re-asserts `REQ_OUT` before `ack_s` has returned to 0.

**Reset**
- All outputs are 0 except `S_READY = 1`.
- State is IDLE, `DATA_OUT = 0`, and the synchronizer chain is cleared.
- `RST` asserted mid-handshake forces this state immediately, without waiting for a clock edge.
- The destination side must tolerate `REQ_OUT` dropping early in that case.

## Timing

- Capture to `REQ_OUT` high: 1 edge (registered).
- `ACK_IN` rising to `REQ_OUT` falling: `SYNC_DEPTH + 1` edges.
- `ACK_IN` falling to `DONE` pulse: `SYNC_DEPTH + 1` edges.
- `DONE` is high in the first IDLE cycle. `S_READY` is high in that same cycle, so the next word can be captured on that edge.
- Minimum cycle per word with a zero-delay destination: `2·(SYNC_DEPTH + 1) + 1` cycles.
- `ack_s` is sampled only in REQ and REL. An ack that is stale or spurious in IDLE is ignored.

## Configuration

**With `CDC_HS_TIMEOUT_EN` defined**
- A counter clears on the IDLE → REQ edge and increments on every edge spent in REQ or REL.
- Timeout fires on the edge where the counter equals `TIMEOUT_CYC - 1` and the awaited `ack_s` transition is absent.
- On timeout: go to ERR, with `REQ_OUT <= 0`, `TIMEOUT_ERR = 1`, `S_READY = 0`, `BUSY = 0`.
- If the awaited ack transition arrives on the same edge as the timeout, the ack transition wins and no timeout occurs.
- ERR → IDLE when `ERR_CLR == 1 && ack_s == 0`, with no `DONE` pulse.

**Without `CDC_HS_TIMEOUT_EN`**
- No counter and no ERR state.
- `TIMEOUT_ERR` is tied to 0 and `ERR_CLR` is ignored.
- A destination that never acknowledges leaves the block in REQ or REL indefinitely.

## Test plan

All scenarios use `SYNC_DEPTH = 2`, `TIMEOUT_CYC = 16`, and the macro defined unless stated otherwise.

1. **Reset:** assert `RST` for 3 cycles. Expect `DATA_OUT = 0`, `REQ_OUT = DONE = BUSY = TIMEOUT_ERR = 0`, `S_READY = 1`.
2. **Single word:** send `0xA5A50001`. The destination raises `ACK_IN` 4 cycles after `REQ_OUT` rises and drops it 4 cycles after `REQ_OUT` falls. Expect `REQ_OUT` to fall 3 edges after `ACK_IN` rises, `DONE` to pulse 3 edges after `ACK_IN` falls, and `DATA_OUT = 0xA5A50001` throughout.
3. **Back-to-back:** hold `S_VALID` with `0x1`, `0x2`, `0x3`. Expect 3 `DONE` pulses, `DATA_OUT` changing only on capture edges, and order preserved.
4. **Busy stability:** toggle `S_DATA` every cycle while in REQ or REL. Expect `S_READY = 0` and `DATA_OUT` unchanged.
5. **Timeout:** `ACK_IN` held at 0. Expect `TIMEOUT_ERR = 1` and `REQ_OUT = 0` 16 edges after capture. Pulse `ERR_CLR`: expect IDLE, `S_READY = 1`, and no `DONE` pulse. Rebuild without the macro: expect `REQ_OUT` to stay at 1 for more than 100 cycles.
6. **Reset mid-handshake:** assert `RST` asynchronously while in REL. Expect all outputs at reset values within the same cycle, and a clean transfer of `0x5A` afterwards.
